// File: rtl/reset_seq.sv
// Power-on/reset sequencer: holds NUM_OUTPUTS reset domains, then releases them in index order.
// Restarts on rst_i, on a debounced external request or on a software pulse, and records the cause.
module reset_seq #(
    parameter int NUM_OUTPUTS  = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_CYCLES = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_PULSE    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ext_rst_req_i,
    input  logic                   sw_rst_req_i,
    output logic [NUM_OUTPUTS-1:0] rst_o,
    output logic                   busy_o,
    output logic [1:0]             cause_o
);

    localparam int MAX_CYC = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int IW      = $clog2(NUM_OUTPUTS + 1);
    localparam int DW      = $clog2(MIN_PULSE + 1);

    localparam logic [CW-1:0]          HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]          STAGE_LAST = CW'(STAGE_CYCLES - 1);
    localparam logic [IW-1:0]          IDX_END    = IW'(NUM_OUTPUTS);
    localparam logic [DW-1:0]          DEB_MAX    = DW'(MIN_PULSE);
    localparam logic [DW-1:0]          DEB_LAST   = DW'(MIN_PULSE - 1);
    localparam logic [NUM_OUTPUTS-1:0] ONE_HOT0   = NUM_OUTPUTS'(1);

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_EXT = 2'd1;
    localparam logic [1:0] CAUSE_SW  = 2'd2;

    if (NUM_OUTPUTS < 1 || NUM_OUTPUTS > 16 || HOLD_CYCLES < 1 || STAGE_CYCLES < 1 ||
        SYNC_STAGES < 2 || MIN_PULSE < 1) begin : g_bad_params
        $error("reset_seq: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STAGE,
        ST_DONE
    } state_t;

    // Declaration initialisers give the same state at configuration as rst_i does.
    state_t                   state_q = ST_HOLD;
    logic [CW-1:0]            cnt_q   = '0;
    logic [IW-1:0]            idx_q   = '0;
    logic [NUM_OUTPUTS-1:0]   rst_o_q = '1;
    logic                     busy_q  = 1'b1;
    logic [1:0]               cause_q = CAUSE_POR;
    logic [SYNC_STAGES-1:0]   sync_q  = '0;
    logic [DW-1:0]            deb_q   = '0;

    state_t                   state_d;
    logic [CW-1:0]            cnt_d;
    logic [IW-1:0]            idx_d;
    logic [NUM_OUTPUTS-1:0]   rst_o_d;
    logic                     busy_d;
    logic [1:0]               cause_d;
    logic [SYNC_STAGES-1:0]   sync_d;
    logic [DW-1:0]            deb_d;

    logic                     ext_synced;
    logic                     ext_restart;
    logic [IW-1:0]            idx_next;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], ext_rst_req_i};
        ext_synced = sync_q[SYNC_STAGES-1];

        if (!ext_synced) begin
            deb_d = '0;
        end else if (deb_q == DEB_MAX) begin
            deb_d = deb_q;
        end else begin
            deb_d = deb_q + DW'(1);
        end

        // Acceptance edge plus every later cycle the request stays high keeps HOLD pinned at zero.
        ext_restart = ext_synced && (deb_q == DEB_LAST || deb_q == DEB_MAX);
        idx_next    = idx_q + IW'(1);

        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_o_d = rst_o_q;
        cause_d = cause_q;

        if (ext_restart || sw_rst_req_i) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_o_d = '1;
            cause_d = ext_restart ? CAUSE_EXT : CAUSE_SW;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    rst_o_d = '1;
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        idx_d   = IW'(1);
                        rst_o_d = rst_o_q & ~ONE_HOT0;
                        state_d = (NUM_OUTPUTS == 1) ? ST_DONE : ST_STAGE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_STAGE: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d   = '0;
                        idx_d   = idx_next;
                        rst_o_d = rst_o_q & ~(ONE_HOT0 << idx_q);
                        if (idx_next == IDX_END) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    rst_o_d = '0;
                end
            endcase
        end

        busy_d = |rst_o_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_o_q <= '1;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_POR;
            sync_q  <= '0;
            deb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_o_q <= rst_o_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
            sync_q  <= sync_d;
            deb_q   <= deb_d;
        end
    end

    assign rst_o   = rst_o_q;
    assign busy_o  = busy_q;
    assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default-parameter instance driven from a vector table,
// plus a single-domain HOLD_CYCLES=1 instance checked by hand.
module tb_reset_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, ext = 1'b0, sw = 1'b0;
    logic [3:0] rst_o;
    logic       busy;
    logic [1:0] cause;

    logic       rst1 = 1'b0;
    logic [0:0] rst_o1;
    logic       busy1;
    logic [1:0] cause1;

    reset_seq dut (
        .clk_i(clk), .rst_i(rst), .ext_rst_req_i(ext), .sw_rst_req_i(sw),
        .rst_o(rst_o), .busy_o(busy), .cause_o(cause)
    );

    reset_seq #(.NUM_OUTPUTS(1), .HOLD_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .ext_rst_req_i(1'b0), .sw_rst_req_i(1'b0),
        .rst_o(rst_o1), .busy_o(busy1), .cause_o(cause1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       r;
        logic       e;
        logic       s;
        int         n;
        logic [3:0] ro;
        logic       b;
        logic [1:0] c;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic e, logic s, int n,
                                logic [3:0] ro, logic b, logic [1:0] c);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.n = n; v.ro = ro; v.b = b; v.c = c;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [3:0] ro, input logic b, input logic [1:0] c);
        check({tag, " rst_o"}, 32'(rst_o), 32'(ro));
        check({tag, " busy_o"}, 32'(busy), 32'(b));
        check({tag, " cause_o"}, 32'(cause), 32'(c));
    endtask

    initial begin
        // Power-up sequence with rst_i never asserted
        step(1);
        check("pwr1 rst_o", 32'(rst_o1), 32'h0);
        check("pwr1 busy_o", 32'(busy1), 32'h0);
        step(14);
        check_main("pwr e15", 4'hF, 1'b1, 2'd0);
        step(1);
        check_main("pwr e16", 4'hE, 1'b1, 2'd0);
        step(8);
        check_main("pwr e24", 4'hC, 1'b1, 2'd0);
        step(8);
        check_main("pwr e32", 4'h8, 1'b1, 2'd0);
        step(7);
        check_main("pwr e39", 4'h8, 1'b1, 2'd0);
        step(1);
        check_main("pwr e40", 4'h0, 1'b0, 2'd0);

        // rst_i for 3 cycles, then full release
        add(1, 0, 0, 3,  4'hF, 1, 0);
        add(0, 0, 0, 15, 4'hF, 1, 0);
        add(0, 0, 0, 1,  4'hE, 1, 0);
        add(0, 0, 0, 7,  4'hE, 1, 0);
        add(0, 0, 0, 1,  4'hC, 1, 0);
        add(0, 0, 0, 8,  4'h8, 1, 0);
        add(0, 0, 0, 8,  4'h0, 0, 0);
        add(0, 0, 0, 5,  4'h0, 0, 0);
        // software pulse from DONE
        add(0, 0, 1, 1,  4'hF, 1, 2);
        add(0, 0, 0, 15, 4'hF, 1, 2);
        add(0, 0, 0, 1,  4'hE, 1, 2);
        add(0, 0, 0, 24, 4'h0, 0, 2);
        // software pulse mid-STAGE at edge 28
        add(1, 0, 0, 1,  4'hF, 1, 0);
        add(0, 0, 0, 27, 4'hC, 1, 0);
        add(0, 0, 1, 1,  4'hF, 1, 2);
        add(0, 0, 0, 15, 4'hF, 1, 2);
        add(0, 0, 0, 1,  4'hE, 1, 2);
        add(0, 0, 0, 24, 4'h0, 0, 2);
        // rst_i and software together: rst_i wins, request dropped
        add(1, 0, 1, 1,  4'hF, 1, 0);
        add(0, 0, 0, 39, 4'h8, 1, 0);
        add(0, 0, 0, 1,  4'h0, 0, 0);
        // 2-cycle external pulse ignored
        add(0, 1, 0, 2,  4'h0, 0, 0);
        add(0, 0, 0, 10, 4'h0, 0, 0);
        // 10-cycle external request, software on the accept edge loses
        add(0, 1, 0, 5,  4'h0, 0, 0);
        add(0, 1, 1, 1,  4'hF, 1, 1);
        add(0, 1, 0, 4,  4'hF, 1, 1);
        add(0, 0, 0, 17, 4'hF, 1, 1);
        add(0, 0, 0, 1,  4'hE, 1, 1);
        add(0, 0, 0, 24, 4'h0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r;
            ext = tbl[i].e;
            sw  = tbl[i].s;
            step(tbl[i].n);
            check_main($sformatf("vec%0d", i), tbl[i].ro, tbl[i].b, tbl[i].c);
        end
        rst = 1'b0; ext = 1'b0; sw = 1'b0;

        // Single domain, HOLD_CYCLES=1
        rst1 = 1'b1;
        step(2);
        check("n1 held rst_o", 32'(rst_o1), 32'h1);
        check("n1 held busy_o", 32'(busy1), 32'h1);
        check("n1 held cause_o", 32'(cause1), 32'h0);
        rst1 = 1'b0;
        step(1);
        check("n1 rel rst_o", 32'(rst_o1), 32'h0);
        check("n1 rel busy_o", 32'(busy1), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
